reg_scoreboard_ctrl: RTL and testbench
======================================

# reg_scoreboard_ctrl

Register-scoreboard hazard controller for the 5-stage pipelined CPU. It keeps one lock counter per architectural register and counts in-flight writers between issue from ID and retire in WB. It raises the PC/IF-ID bubble when the instruction in ID reads a locked register, and sequences the halt drain once the `0xffffffff` halt word reaches ID. It sits beside the ID stage and replaces the per-register `reg_lock` bookkeeping inside the CPU core.

## Interface
- `NREG`, 32: number of architectural registers; register 0 is never locked.
- `CNT_W`, 4: lock counter width; saturation value is 2^CNT_W−1.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs_used` / `id_rsc`  in  1 / 5  ID reads rs; rs index.
- `id_rt_used` / `id_rtc`  in  1 / 5  ID reads rt; rt index.
- `id_wr_en` / `id_wrc`  in  1 / 5  ID instruction will write register `id_wrc`.
- `id_is_halt`  in  1  ID instruction equals `32'hffffffff`.
- `flush`  in  1  taken branch/jump; kills the ID instruction this cycle.
- `wb_wen` / `wb_rdc`  in  1 / 5  WB writes register `wb_rdc` this cycle.
- `stall`  out  1  bubble request: hold PC and IF/ID, inject NOP into ID/EX.
- `issue`  out  1  ID instruction advances into EX this cycle.
- `halt`  out  1  pipeline drained and stopped.
- `lock_busy`  out  NREG  bit i = counter i nonzero.
- `lock_err`  out  1  sticky: retire seen on a zero counter.

## Operation
- Counters `lock[i]` for i = 1..NREG−1. `lock[0]` is constantly 0. Writes to register 0 are ignored on both issue and retire.
- Hazard (combinational, from registered counters only): `haz = (id_rs_used & lock[id_rsc]≠0) | (id_rt_used & lock[id_rtc]≠0) | (id_wr_en & lock[id_wrc]==max)`.
- There is no same-cycle WB bypass. A retire in cycle N clears the hazard from cycle N+1 onward.
- FSM states:
  - RUN → DRAIN: when `id_valid & id_is_halt & ~flush & ~haz`. The halt word is not issued.
  - DRAIN → HALTED: when all counters are zero, evaluated on registered state.
  - HALTED: holds until `reset`.
- `stall`:
  - RUN: `id_valid & ~flush & haz`.
  - DRAIN and HALTED: 1.
- `issue`: `state==RUN & id_valid & ~flush & ~haz & ~id_is_halt`.
- `halt`: `state==HALTED` (registered).
- Counter update each edge, per register i:
  - `inc = issue & id_wr_en & id_wrc==i`.
  - `dec = wb_wen & wb_rdc==i`.
  - inc & dec → unchanged.
  - inc only → +1. Saturation cannot occur because `haz` blocks issue at max.
  - dec only → −1 if nonzero. If already zero, the counter stays 0 and `lock_err` is set.
- `flush` has priority over everything in ID. Flush with a hazard → `stall=0`, `issue=0`, no counter increment.
- Retires continue in every state, including DRAIN and HALTED.

## Timing
- Reset values: all counters 0, state RUN, `halt`=0, `lock_err`=0, `lock_busy`=0.
- While `reset`=1, `stall` and `issue` are forced to 0.
- `stall` and `issue` are combinational with zero latency from ID inputs. There is no combinational path from `wb_*` to `stall` or `issue`.
- Issue-to-visible lock: a writer issued in cycle N sets `lock_busy[wrc]` in cycle N+1.
- Retire-to-clear: a retire in cycle N with count 1 clears `lock_busy` and `stall` in cycle N+1.
- `halt` rises exactly one cycle after the edge on which DRAIN observes all counters zero. The minimum is 1 cycle after entering DRAIN.
- A reset asserted mid-DRAIN or mid-HALTED returns to RUN with counters cleared on that edge. In-flight retires that arrive afterwards hit zero counters and set `lock_err`; the bench must flush the pipeline alongside reset.

## Test plan
- RAW stall: issue `id_wr_en=1, id_wrc=8`. Next cycle ID reads rs=8 → `stall=1`, `issue=0`. Retire `wb_rdc=8` in cycle N → `stall=0`, `issue=1` in N+1, and `lock_busy[8]` clears in N+1.
- Multiple writers: issue 3 writers to r5 with no reads → `lock[5]=3`. Retire 2 → `lock_busy[5]` still 1. Retire 3rd → `lock_busy[5]=0`.
- Same-cycle inc/dec: issue a writer to r9 while WB retires r9 with `lock[9]=1` → `lock[9]` stays 1. No `lock_err`.
- Register 0 and flush:
  - Writer to r0 → `lock_busy=0`, and a following read of r0 never stalls.
  - Hazarded read with `flush=1` → `stall=0`, `issue=0`, counters unchanged.
- Saturation and error:
  - With `CNT_W=2`, 3 writers to r4 then a 4th → `stall=1`.
  - Retire on an idle r7 → `lock_err=1`, and it stays 1 until reset.
- Halt drain: r2 and r3 locked, halt word in ID → `stall=1`, state DRAIN, `halt=0`. Last retire in cycle N → `halt=1` at cycle N+2. Assert `reset` → `halt=0`, `stall=0` after the edge.

Source files
------------

// File: rtl/reg_scoreboard_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_ctrl_if : ID/WB handshake bundle for the scoreboard controller
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface reg_scoreboard_ctrl_if #(
  parameter int NREG = 32
);
  logic            id_valid;
  logic            id_rs_used;
  logic [4:0]      id_rsc;
  logic            id_rt_used;
  logic [4:0]      id_rtc;
  logic            id_wr_en;
  logic [4:0]      id_wrc;
  logic            id_is_halt;
  logic            flush;
  logic            wb_wen;
  logic [4:0]      wb_rdc;
  logic            stall;
  logic            issue;
  logic            halt;
  logic [NREG-1:0] lock_busy;
  logic            lock_err;

  modport master (
    output id_valid, id_rs_used, id_rsc, id_rt_used, id_rtc,
           id_wr_en, id_wrc, id_is_halt, flush, wb_wen, wb_rdc,
    input  stall, issue, halt, lock_busy, lock_err
  );

  modport slave (
    input  id_valid, id_rs_used, id_rsc, id_rt_used, id_rtc,
           id_wr_en, id_wrc, id_is_halt, flush, wb_wen, wb_rdc,
    output stall, issue, halt, lock_busy, lock_err
  );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_ctrl : per-register lock counters, RAW/WAW bubble, halt drain
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_scoreboard_ctrl #(
  parameter int NREG  = 32,
  parameter int CNT_W = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  reg_scoreboard_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        lock_err_q, lock_err_d;
  logic [NREG-1:0][CNT_W-1:0]  lock_cnt;
  logic [NREG-1:0]             busy;
  logic [NREG-1:0]             err_vec;
  logic                        haz;
  logic                        stall_w;
  logic                        issue_w;

  // Hazard looks only at registered counters: no WB bypass path.
  always_comb begin
    haz = (bus.id_rs_used & busy[bus.id_rsc])
        | (bus.id_rt_used & busy[bus.id_rtc])
        | (bus.id_wr_en   & (lock_cnt[bus.id_wrc] == CNT_MAX));
  end

  always_comb begin
    state_d = state_q;
    stall_w = 1'b0;
    issue_w = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.id_valid && !bus.flush) begin
          if (haz)                 stall_w = 1'b1;
          else if (bus.id_is_halt) state_d = ST_DRAIN;
          else                     issue_w = 1'b1;
        end
      end
      ST_DRAIN: begin
        stall_w = 1'b1;
        if (busy == '0) state_d = ST_HALTED;
      end
      ST_HALTED: stall_w = 1'b1;
      default:   state_d = ST_RUN;
    endcase
    if (reset) begin
      stall_w = 1'b0;
      issue_w = 1'b0;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_lock
    if (i == 0) begin : g_zero
      assign lock_cnt[i] = '0;
      assign err_vec[i]  = 1'b0;
    end else begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             inc, dec;

      assign inc = issue_w & bus.id_wr_en & (bus.id_wrc == 5'(i));
      assign dec = bus.wb_wen & (bus.wb_rdc == 5'(i));

      always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec)
          cnt_d = cnt_q + 1'b1;
        else if (dec && !inc && cnt_q != '0)
          cnt_d = cnt_q - 1'b1;
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign lock_cnt[i] = cnt_q;
      // A retire with no matching writer in flight means the pipeline lost track.
      assign err_vec[i]  = dec & ~inc & (cnt_q == '0);
    end
    assign busy[i] = |lock_cnt[i];
  end

  assign lock_err_d = lock_err_q | (|err_vec);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign bus.stall     = stall_w;
  assign bus.issue     = issue_w;
  assign bus.halt      = (state_q == ST_HALTED);
  assign bus.lock_busy = busy;
  assign bus.lock_err  = lock_err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard_ctrl : directed bench, 2-bit counters so saturation is reachable
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_scoreboard_ctrl;

  localparam int NREG  = 32;
  localparam int CNT_W = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reg_scoreboard_ctrl_if #(.NREG(NREG)) bus ();

  reg_scoreboard_ctrl #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then leave room to drive inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.id_valid   = 1'b0;
    bus.id_rs_used = 1'b0;
    bus.id_rsc     = 5'd0;
    bus.id_rt_used = 1'b0;
    bus.id_rtc     = 5'd0;
    bus.id_wr_en   = 1'b0;
    bus.id_wrc     = 5'd0;
    bus.id_is_halt = 1'b0;
    bus.flush      = 1'b0;
    bus.wb_wen     = 1'b0;
    bus.wb_rdc     = 5'd0;
  endtask

  task automatic writer(input logic [4:0] r);
    idle();
    bus.id_valid = 1'b1;
    bus.id_wr_en = 1'b1;
    bus.id_wrc   = r;
  endtask

  task automatic reader(input logic [4:0] r);
    idle();
    bus.id_valid   = 1'b1;
    bus.id_rs_used = 1'b1;
    bus.id_rsc     = r;
  endtask

  task automatic retire(input logic [4:0] r);
    idle();
    bus.wb_wen = 1'b1;
    bus.wb_rdc = r;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b1;
    tick();
    // Outputs forced low during reset even with a clean writer in ID.
    writer(5'd1);
    settle();
    chk("rst_issue", {31'd0, bus.issue}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    reset = 1'b0;
    idle();
    settle();
    chk("rst_busy", bus.lock_busy, 32'd0);
    chk("rst_halt", {31'd0, bus.halt}, 32'd0);
    chk("rst_err", {31'd0, bus.lock_err}, 32'd0);

    // RAW on r8
    writer(5'd8);
    settle();
    chk("raw_issue_wr", {31'd0, bus.issue}, 32'd1);
    tick();
    reader(5'd8);
    bus.wb_wen = 1'b1;
    bus.wb_rdc = 5'd8;
    settle();
    chk("raw_busy8", bus.lock_busy, 32'h0000_0100);
    chk("raw_stall", {31'd0, bus.stall}, 32'd1);
    chk("raw_noissue", {31'd0, bus.issue}, 32'd0);
    tick();
    reader(5'd8);
    settle();
    chk("raw_clear_stall", {31'd0, bus.stall}, 32'd0);
    chk("raw_clear_issue", {31'd0, bus.issue}, 32'd1);
    chk("raw_clear_busy", bus.lock_busy, 32'd0);
    tick();

    // Three writers to r5, fourth saturates the 2-bit counter
    for (int k = 0; k < 3; k++) begin
      writer(5'd5);
      settle();
      chk("mw_issue", {31'd0, bus.issue}, 32'd1);
      tick();
    end
    writer(5'd5);
    settle();
    chk("sat_stall", {31'd0, bus.stall}, 32'd1);
    chk("sat_noissue", {31'd0, bus.issue}, 32'd0);
    retire(5'd5);
    tick();
    retire(5'd5);
    tick();
    idle();
    settle();
    chk("mw_busy_after2", bus.lock_busy, 32'h0000_0020);
    retire(5'd5);
    tick();
    idle();
    settle();
    chk("mw_busy_after3", bus.lock_busy, 32'd0);

    // Same-cycle inc/dec on r9 keeps the count at 1
    writer(5'd9);
    tick();
    writer(5'd9);
    bus.wb_wen = 1'b1;
    bus.wb_rdc = 5'd9;
    settle();
    chk("sc_issue", {31'd0, bus.issue}, 32'd1);
    tick();
    idle();
    settle();
    chk("sc_busy", bus.lock_busy, 32'h0000_0200);
    chk("sc_err", {31'd0, bus.lock_err}, 32'd0);
    retire(5'd9);
    tick();
    idle();
    settle();
    chk("sc_busy_clear", bus.lock_busy, 32'd0);
    chk("sc_err2", {31'd0, bus.lock_err}, 32'd0);

    // Register 0 never locks
    writer(5'd0);
    settle();
    chk("r0_issue", {31'd0, bus.issue}, 32'd1);
    tick();
    reader(5'd0);
    bus.id_rt_used = 1'b1;
    bus.id_rtc     = 5'd0;
    settle();
    chk("r0_busy", bus.lock_busy, 32'd0);
    chk("r0_nostall", {31'd0, bus.stall}, 32'd0);
    tick();

    // Flush beats a hazard and suppresses the increment
    writer(5'd6);
    tick();
    reader(5'd6);
    bus.id_wr_en = 1'b1;
    bus.id_wrc   = 5'd10;
    bus.flush    = 1'b1;
    settle();
    chk("fl_stall", {31'd0, bus.stall}, 32'd0);
    chk("fl_issue", {31'd0, bus.issue}, 32'd0);
    tick();
    idle();
    settle();
    chk("fl_busy", bus.lock_busy, 32'h0000_0040);
    retire(5'd6);
    tick();
    idle();
    settle();
    chk("fl_busy_clear", bus.lock_busy, 32'd0);

    // Retire on idle r7 sets a sticky error
    retire(5'd7);
    tick();
    idle();
    settle();
    chk("err_set", {31'd0, bus.lock_err}, 32'd1);
    chk("err_busy", bus.lock_busy, 32'd0);
    tick();
    tick();
    chk("err_sticky", {31'd0, bus.lock_err}, 32'd1);

    // Halt drain with r2 and r3 in flight
    writer(5'd2);
    tick();
    writer(5'd3);
    tick();
    idle();
    bus.id_valid   = 1'b1;
    bus.id_is_halt = 1'b1;
    settle();
    chk("hl_run_noissue", {31'd0, bus.issue}, 32'd0);
    chk("hl_run_nostall", {31'd0, bus.stall}, 32'd0);
    tick();
    retire(5'd2);
    bus.id_valid   = 1'b1;
    bus.id_is_halt = 1'b1;
    settle();
    chk("hl_drain_stall", {31'd0, bus.stall}, 32'd1);
    chk("hl_drain_halt", {31'd0, bus.halt}, 32'd0);
    tick();
    retire(5'd3);
    bus.id_valid   = 1'b1;
    bus.id_is_halt = 1'b1;
    settle();
    chk("hl_n_halt", {31'd0, bus.halt}, 32'd0);
    tick();
    idle();
    settle();
    chk("hl_n1_halt", {31'd0, bus.halt}, 32'd0);
    chk("hl_n1_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    chk("hl_n2_halt", {31'd0, bus.halt}, 32'd1);
    chk("hl_n2_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    chk("hl_hold", {31'd0, bus.halt}, 32'd1);

    // Reset returns to RUN and clears everything
    reset = 1'b1;
    settle();
    chk("hr_stall_in_rst", {31'd0, bus.stall}, 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("hr_halt", {31'd0, bus.halt}, 32'd0);
    chk("hr_stall", {31'd0, bus.stall}, 32'd0);
    chk("hr_err", {31'd0, bus.lock_err}, 32'd0);
    writer(5'd4);
    settle();
    chk("hr_run_issue", {31'd0, bus.issue}, 32'd1);
    tick();
    idle();
    settle();
    chk("hr_busy4", bus.lock_busy, 32'h0000_0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
